// File: rtl/aes_data_buffer_if.sv
// Bus-side bundle for the AES data buffer.
// Controller/bus drives inputs; buffer drives block and read words.
interface aes_data_buffer_if;
  logic         clear;
  logic         ahb_mode;
  logic         ahb_shift_en;
  logic [31:0]  hwdata;
  logic         enc_done;
  logic [127:0] enc_result;
  logic [127:0] block_out;
  logic         block_valid;
  logic [31:0]  hrdata;
  logic         rd_valid;
  logic         tx_empty;
  logic         tx_done;
  logic         err;

  modport master (
    output clear, ahb_mode, ahb_shift_en, hwdata,
    output enc_done, enc_result,
    input  block_out, block_valid, hrdata, rd_valid,
    input  tx_empty, tx_done, err
  );

  modport slave (
    input  clear, ahb_mode, ahb_shift_en, hwdata,
    input  enc_done, enc_result,
    output block_out, block_valid, hrdata, rd_valid,
    output tx_empty, tx_done, err
  );
endinterface

// File: rtl/aes_data_buffer.sv
// Word <-> block staging between the bus and the AES core.
// Write path packs 4 words; read path unloads a result word by word.
module aes_data_buffer (
  input  logic                clk,
  input  logic                n_rst,
  aes_data_buffer_if.slave    bus
);

  typedef enum logic {
    TX_EMPTY  = 1'b0,
    TX_LOADED = 1'b1
  } tx_state_t;

  tx_state_t    state, state_nxt;
  logic [1:0]   rx_ct;
  logic [127:0] rx_reg;
  logic [1:0]   tx_ct;
  logic [127:0] tx_reg;

  logic wr_stb, rd_stb;
  logic rd_fire, rd_last, overrun, underrun;
  logic [31:0] tx_word;

  assign wr_stb = bus.ahb_shift_en & ~bus.ahb_mode;
  assign rd_stb = bus.ahb_shift_en & bus.ahb_mode;
  assign bus.tx_empty = (state == TX_EMPTY);

  // Write path: shift words in, publish the block on the 4th word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_ct           <= 2'd0;
      rx_reg          <= '0;
      bus.block_out   <= '0;
      bus.block_valid <= 1'b0;
    end else if (bus.clear) begin
      rx_ct           <= 2'd0;
      bus.block_valid <= 1'b0;
    end else begin
      bus.block_valid <= 1'b0;
      if (wr_stb) begin
        rx_reg <= {rx_reg[95:0], bus.hwdata};
        rx_ct  <= rx_ct + 2'd1;
        if (rx_ct == 2'd3) begin
          bus.block_out   <= {rx_reg[95:0], bus.hwdata};
          bus.block_valid <= 1'b1;
        end
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= TX_EMPTY;
    else        state <= state_nxt;
  end

  // Read FSM next state: a new result always wins over a read.
  always_comb begin
    state_nxt = state;
    if (bus.clear)         state_nxt = TX_EMPTY;
    else if (bus.enc_done) state_nxt = TX_LOADED;
    else if (rd_last)      state_nxt = TX_EMPTY;
  end

  // Read FSM outputs: classify this cycle's read/load events.
  always_comb begin
    rd_fire  = 1'b0;
    rd_last  = 1'b0;
    overrun  = 1'b0;
    underrun = 1'b0;
    unique case (state)
      TX_LOADED: begin
        overrun = bus.enc_done;
        rd_fire = rd_stb & ~bus.enc_done;
        rd_last = rd_fire & (tx_ct == 2'd3);
      end
      TX_EMPTY: begin
        underrun = rd_stb & ~bus.enc_done;
      end
      default: ;
    endcase
  end

  // Word 0 is the most significant word of the result.
  always_comb begin
    tx_word = tx_reg[127:96];
    unique case (tx_ct)
      2'd0: tx_word = tx_reg[127:96];
      2'd1: tx_word = tx_reg[95:64];
      2'd2: tx_word = tx_reg[63:32];
      2'd3: tx_word = tx_reg[31:0];
      default: ;
    endcase
  end

  // Read datapath: result load, word unload, pulses and sticky error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_ct        <= 2'd0;
      tx_reg       <= '0;
      bus.hrdata   <= '0;
      bus.rd_valid <= 1'b0;
      bus.tx_done  <= 1'b0;
      bus.err      <= 1'b0;
    end else if (bus.clear) begin
      tx_ct        <= 2'd0;
      bus.rd_valid <= 1'b0;
      bus.tx_done  <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire;
      bus.tx_done  <= rd_last;
      bus.err      <= bus.err | overrun | underrun;
      if (bus.enc_done) begin
        tx_reg <= bus.enc_result;
        tx_ct  <= 2'd0;
      end else if (rd_fire) begin
        bus.hrdata <= tx_word;
        tx_ct      <= tx_ct + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_data_buffer.sv
// Directed bench for aes_data_buffer.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_aes_data_buffer;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  aes_data_buffer_if bus ();

  aes_data_buffer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] R1 =
    128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] R2 =
    128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] R3 =
    128'h55555555_66666666_77777777_88888888;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.clear        = 1'b0;
    bus.ahb_mode     = 1'b0;
    bus.ahb_shift_en = 1'b0;
    bus.hwdata       = '0;
    bus.enc_done     = 1'b0;
    bus.enc_result   = '0;
  endtask

  task automatic cyc(input logic se, input logic md,
                     input logic [31:0] wd, input logic ed,
                     input logic [127:0] er, input logic cl);
    @(negedge clk);
    bus.ahb_shift_en = se;
    bus.ahb_mode     = md;
    bus.hwdata       = wd;
    bus.enc_done     = ed;
    bus.enc_result   = er;
    bus.clear        = cl;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [31:0] w);
    cyc(1'b1, 1'b0, w, 1'b0, '0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b1, 1'b1, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic enc(input logic [127:0] r);
    cyc(1'b0, 1'b0, '0, 1'b1, r, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_w [4];
    checks = 0;
    errors = 0;
    idle();
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_block_out", bus.block_out, '0);
    chk("rst_hrdata", bus.hrdata, '0);
    chk("rst_block_valid", bus.block_valid, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_tx_done", bus.tx_done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_tx_empty", bus.tx_empty, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;

    wr(32'h00112233);
    wr(32'h44556677);
    wr(32'h8899AABB);
    chk("partial_valid", bus.block_valid, 1'b0);
    chk("partial_block", bus.block_out, '0);
    wr(32'hCCDDEEFF);
    chk("blk_valid", bus.block_valid, 1'b1);
    chk("blk_out", bus.block_out,
        128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(posedge clk);
    #1;
    chk("blk_valid_pulse", bus.block_valid, 1'b0);

    enc(R1);
    chk("load_tx_empty", bus.tx_empty, 1'b0);
    exp_w[0] = 32'hA0A1A2A3;
    exp_w[1] = 32'hB0B1B2B3;
    exp_w[2] = 32'hC0C1C2C3;
    exp_w[3] = 32'hD0D1D2D3;
    for (int i = 0; i < 4; i++) begin
      rd();
      chk($sformatf("rd%0d_valid", i), bus.rd_valid, 1'b1);
      chk($sformatf("rd%0d_data", i), bus.hrdata, exp_w[i]);
      chk($sformatf("rd%0d_done", i), bus.tx_done, i == 3);
    end
    chk("unload_empty", bus.tx_empty, 1'b1);
    chk("unload_err", bus.err, 1'b0);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.tx_done, 1'b0);

    rd();
    chk("under_rd_valid", bus.rd_valid, 1'b0);
    chk("under_hrdata", bus.hrdata, 32'hD0D1D2D3);
    chk("under_err", bus.err, 1'b1);
    clr();
    chk("clr_err", bus.err, 1'b0);
    chk("clr_hrdata_kept", bus.hrdata, 32'hD0D1D2D3);

    enc(R1);
    rd();
    chk("ovr_rd0", bus.hrdata, 32'hA0A1A2A3);
    rd();
    chk("ovr_rd1", bus.hrdata, 32'hB0B1B2B3);
    chk("ovr_err_before", bus.err, 1'b0);
    enc(R2);
    chk("ovr_err", bus.err, 1'b1);
    chk("ovr_loaded", bus.tx_empty, 1'b0);
    rd();
    chk("ovr_new_w0", bus.hrdata, 32'h11111111);
    clr();

    enc(R1);
    cyc(1'b1, 1'b1, '0, 1'b1, R3, 1'b0);
    chk("coin_rd_valid", bus.rd_valid, 1'b0);
    chk("coin_err", bus.err, 1'b1);
    chk("coin_hrdata", bus.hrdata, 32'h11111111);
    rd();
    chk("coin_next_w0", bus.hrdata, 32'h55555555);
    clr();
    chk("clr_empty", bus.tx_empty, 1'b1);

    cyc(1'b1, 1'b1, '0, 1'b1, R2, 1'b0);
    chk("ld_empty_err", bus.err, 1'b0);
    chk("ld_empty_rdv", bus.rd_valid, 1'b0);
    chk("ld_empty_state", bus.tx_empty, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, R1, 1'b1);
    chk("clr_over_enc", bus.tx_empty, 1'b1);
    chk("clr_over_err", bus.err, 1'b0);

    wr(32'h1111AAAA);
    wr(32'h2222BBBB);
    clr();
    wr(32'h9);
    wr(32'hA);
    wr(32'hB);
    chk("clr_rx_partial", bus.block_valid, 1'b0);
    chk("clr_block_kept", bus.block_out,
        128'h00112233_44556677_8899AABB_CCDDEEFF);
    wr(32'hC);
    chk("clr_rx_valid", bus.block_valid, 1'b1);
    chk("clr_rx_block", bus.block_out,
        128'h00000009_0000000A_0000000B_0000000C);

    wr(32'h10);
    wr(32'h20);
    wr(32'h30);
    cyc(1'b1, 1'b0, 32'h40, 1'b1, R1, 1'b0);
    chk("par_valid", bus.block_valid, 1'b1);
    chk("par_block", bus.block_out,
        128'h00000010_00000020_00000030_00000040);
    chk("par_loaded", bus.tx_empty, 1'b0);
    rd();
    chk("par_rd0", bus.hrdata, 32'hA0A1A2A3);
    clr();

    wr(32'hDEAD0001);
    wr(32'hDEAD0002);
    rst_pulse();
    chk("mid_rst_block", bus.block_out, '0);
    chk("mid_rst_hrdata", bus.hrdata, '0);
    wr(32'h1);
    wr(32'h2);
    wr(32'h3);
    chk("mid_rst_partial", bus.block_valid, 1'b0);
    wr(32'h4);
    chk("mid_rst_valid", bus.block_valid, 1'b1);
    chk("mid_rst_out", bus.block_out,
        128'h00000001_00000002_00000003_00000004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_data_buffer.md
AES_DATA_BUFFER -- requirements
Module: aes_data_buffer

Interface
REQ-001 Parameters: none; word width fixed at 32 bits, block width fixed at 128 bits (4 words).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 n_rst  in  1  asynchronous, active-low reset.
REQ-004 clear  in  1  synchronous flush of both paths, from controller IDLE.
REQ-005 ahb_mode  in  1  0 = write path (shift word in), 1 = read path (shift word out).
REQ-006 ahb_shift_en  in  1  one-cycle strobe; moves one word in the direction given by ahb_mode.
REQ-007 hwdata  in  32  word written by bus interface.
REQ-008 enc_done  in  1  one-cycle pulse from AES core; enc_result is valid in that cycle.
REQ-009 enc_result  in  128  processed block from AES core.
REQ-010 block_out  out  128  assembled input block to AES core / key path.
REQ-011 block_valid  out  1  one-cycle pulse: block_out newly complete.
REQ-012 hrdata  out  32  registered read word to bus interface.
REQ-013 rd_valid  out  1  one-cycle pulse: hrdata updated.
REQ-014 tx_empty  out  1  high when no unread result words remain.
REQ-015 tx_done  out  1  one-cycle pulse after the 4th result word is read.
REQ-016 err  out  1  sticky error flag (overrun or underrun).

Function
REQ-017 Write path: 2-bit rx_ct; each write strobe (ahb_shift_en=1, ahb_mode=0) shifts hwdata into an internal 128-bit register, first word ending at bits [127:96], fourth at [31:0].
REQ-018 On the 4th write strobe, copy the full word set into block_out on that edge, assert block_valid for exactly the next cycle, and wrap rx_ct to 0.
REQ-019 block_out holds its value until the next completed block; partial writes never change block_out.
REQ-020 Read path FSM states: TX_EMPTY, TX_LOADED; tx_empty = (state == TX_EMPTY).
REQ-021 enc_done in any state loads enc_result into tx register, sets tx_ct = 0, next state TX_LOADED.
REQ-022 enc_done in TX_LOADED with tx_ct != 0, or with no word yet read, sets err (overrun); the new result still replaces the old one.
REQ-023 Read strobe (ahb_shift_en=1, ahb_mode=1) in TX_LOADED: hrdata <= word tx_ct (word 0 = bits [127:96]), rd_valid pulses next cycle, tx_ct increments.
REQ-024 Read strobe for word 3: state -> TX_EMPTY, tx_done pulses in the same cycle as rd_valid, tx_ct wraps to 0.
REQ-025 Read strobe in TX_EMPTY: hrdata unchanged, no rd_valid, err set (underrun).
REQ-026 Same-cycle enc_done and read strobe: enc_done wins; tx register reloads, tx_ct = 0, no rd_valid, err set only if REQ-022 applies.
REQ-027 A write strobe and enc_done in the same cycle are independent; both take effect.
REQ-028 clear: rx_ct = 0, tx_ct = 0, state TX_EMPTY, err = 0; block_out and hrdata keep their values; clear overrides strobes and enc_done in the same cycle.
REQ-029 Latency: block_valid 1 cycle after the 4th write strobe; hrdata/rd_valid 1 cycle after a read strobe.

Reset
REQ-030 n_rst low: block_out = 0, hrdata = 0, block_valid = 0, rd_valid = 0, tx_done = 0, err = 0, tx_empty = 1, rx_ct = 0, tx_ct = 0, immediately and independent of clk.
REQ-031 Reset mid-block discards partial words; the next write strobe after release is treated as word 0.

Verification
REQ-032 Writes 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF -> block_valid one cycle after the 4th, block_out = 0x00112233_44556677_8899AABB_CCDDEEFF.
REQ-033 enc_done with result 0xA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, then 4 reads -> hrdata A0A1A2A3, B0B1B2B3, C0C1C2C3, D0D1D2D3; tx_done with the last word; tx_empty = 1; err = 0.
REQ-034 Read strobe with tx_empty = 1 -> no rd_valid, hrdata unchanged, err = 1; clear -> err = 0.
REQ-035 enc_done, 2 reads, enc_done with a new result -> err = 1; the next read returns word 0 of the new result.
REQ-036 2 writes, n_rst pulse, 4 writes of 0x1, 0x2, 0x3, 0x4 -> block_out = 0x00000001_00000002_00000003_00000004.
REQ-037 enc_done coincident with a read strobe in TX_LOADED after 0 reads -> no rd_valid, tx_ct = 0, err = 1.
